// File: rtl/ahb_apb_bridge_p.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_bridge_p
//  Purpose  : AHB-Lite slave to multi-slave APB bridge. Accepts one AHB
//             transfer at a time, decodes it onto one of NUM_SLV APB windows
//             of 2**SPAN_W bytes starting at BASE_ADDR, runs the APB
//             SETUP/ACCESS handshake and returns the result on AHB.
//             Out-of-window addresses and APB slave errors produce a
//             two-cycle AHB ERROR response.
//  Ports    : Hclk, Hresetn            - clock, async active-low reset
//             Hwrite/Hreadyin/Htrans/Haddr/Hwdata - AHB request side
//             Hreadyout/Hresp/Hrdata   - AHB response side
//             Prdata/Pready/Pslverr    - per-slave APB responses (packed)
//             Pselx/Penable/Pwrite/Paddr/Pwdata - APB request side
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_apb_bridge_p #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int                SPAN_W    = 12
) (
    input  logic                      Hclk,
    input  logic                      Hresetn,
    // AHB side
    input  logic                      Hwrite,
    input  logic                      Hreadyin,
    input  logic [1:0]                Htrans,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    output logic                      Hreadyout,
    output logic [1:0]                Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    // APB side
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr,
    output logic [NUM_SLV-1:0]        Pselx,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata
);

    localparam int                c_idx_w   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [ADDR_W-1:0] c_num_slv = ADDR_W'(NUM_SLV);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WWAIT  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_idx_w-1:0] r_idx;

    logic [ADDR_W-1:0]  w_offset;
    logic [ADDR_W-1:0]  w_slot;
    logic               w_hit;
    logic               w_sel_ready;
    logic               w_sel_err;
    logic               w_done_ok;
    logic               w_hreadyout;
    logic               w_accept;
    logic               w_load;
    state_t             w_load_state;

    // Address decode of the request currently on the AHB address phase
    always_comb begin
        w_offset = Haddr - BASE_ADDR;
        w_slot   = w_offset >> SPAN_W;
        w_hit    = (Haddr >= BASE_ADDR) && (w_slot < c_num_slv);
    end

    // Response of the slave currently addressed
    always_comb begin
        w_sel_ready = Pready[r_idx];
        w_sel_err   = Pslverr[r_idx];
        w_done_ok   = (r_state == S_ACCESS) && w_sel_ready && !w_sel_err;
    end

    // Ready/response are combinational so a completing ACCESS cycle can
    // accept the next address phase in the same cycle (no IDLE bubble).
    always_comb begin
        w_hreadyout = (r_state == S_IDLE) || (r_state == S_ERR2) || w_done_ok;
        Hreadyout   = w_hreadyout;
        Hresp       = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
        Hrdata      = '0;
        if ((r_state == S_ACCESS) && w_sel_ready && !Pwrite) begin
            Hrdata = Prdata[r_idx*DATA_W +: DATA_W];
        end
    end

    // ERR2 also drives Hreadyout high but must not start a new transfer,
    // so loading is restricted to IDLE and a clean ACCESS completion.
    always_comb begin
        w_accept     = Hreadyin && w_hreadyout && Htrans[1];
        w_load       = w_accept && ((r_state == S_IDLE) || w_done_ok);
        w_load_state = !w_hit ? S_ERR1 : (Hwrite ? S_WWAIT : S_SETUP);
    end

    // APB select/enable are pure decodes of the registered state and index
    always_comb begin
        Pselx   = '0;
        Penable = (r_state == S_ACCESS);
        if ((r_state == S_SETUP) || (r_state == S_ACCESS)) begin
            Pselx[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            Paddr   <= '0;
            Pwrite  <= 1'b0;
            Pwdata  <= '0;
        end else begin
            if (w_load) begin
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
                r_idx  <= w_slot[c_idx_w-1:0];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= w_load_state;
                    end
                end
                S_WWAIT: begin
                    // Write data arrives in the AHB data phase, one cycle
                    // after the address.
                    Pwdata  <= Hwdata;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        if (w_sel_err) begin
                            r_state <= S_ERR1;
                        end else if (w_load) begin
                            r_state <= w_load_state;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                end
                S_ERR2: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_apb_bridge_p
//  Purpose  : Self-checking bench for ahb_apb_bridge_p. A vector table of
//             AHB transfers is streamed back-to-back; expected responses are
//             queued when a transfer is presented and compared when the
//             bridge completes it. Hand-written sequences cover reset, idle
//             and busy transfers, and reset during an ACCESS wait state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_apb_bridge_p;

    logic         Hclk;
    logic         Hresetn;
    logic         Hwrite;
    logic         Hreadyin;
    logic [1:0]   Htrans;
    logic [31:0]  Haddr;
    logic [31:0]  Hwdata;
    logic         Hreadyout;
    logic [1:0]   Hresp;
    logic [31:0]  Hrdata;
    logic [127:0] Prdata;
    logic [3:0]   Pready;
    logic [3:0]   Pslverr;
    logic [3:0]   Pselx;
    logic         Penable;
    logic         Pwrite;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;

    ahb_apb_bridge_p dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic [31:0] pdata;   // data returned by the addressed slave
        int          waits;   // ACCESS cycles with Pready low
        logic        slverr;
        logic [1:0]  resp;    // expected AHB response
        logic [3:0]  sel;     // expected Pselx (zero for a decode miss)
        int          lat;     // expected cycles from address edge to ready
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  sel;
        int          lat;
    } exp_t;

    vec_t vt[13];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    // Streams vt[lo..hi]; a new transfer is presented whenever the bridge is
    // ready, except in the cycle an ERROR response completes.
    task automatic run_vectors(input int lo, input int hi);
        int          nxt      = lo;
        int          cur      = -1;
        bit          inflight = 1'b0;
        bit          blocked;
        int          lat      = 0;
        int          acc      = 0;
        int          budget   = 0;
        logic [3:0]  selseen  = '0;
        logic [31:0] paddr_c  = '0;
        logic [31:0] pwdata_c = '0;
        logic        pwrite_c = 1'b0;
        exp_t        e;
        while ((nxt <= hi || inflight) && budget < 200) begin
            blocked = 1'b0;
            if (cur >= 0) begin
                for (int i = 0; i < 4; i++) begin
                    Prdata[i*32 +: 32] = vt[cur].sel[i] ? vt[cur].pdata : ~vt[cur].pdata;
                end
                Hwdata = vt[cur].wdata;
                if (Penable) begin
                    Pready  = (acc >= vt[cur].waits) ? 4'hF : 4'h0;
                    Pslverr = vt[cur].slverr ? 4'hF : 4'h0;
                    acc++;
                end else begin
                    Pready  = 4'h0;
                    Pslverr = 4'h0;
                end
            end
            #1;
            if (inflight) begin
                lat++;
                selseen = selseen | Pselx;
                if (Penable) begin
                    paddr_c  = Paddr;
                    pwrite_c = Pwrite;
                    pwdata_c = Pwdata;
                end
                if (Hreadyout) begin
                    inflight = 1'b0;
                    if (sb.size() == 0) begin
                        check("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("v%0d_resp", cur), 32'(Hresp), 32'(e.resp));
                        check($sformatf("v%0d_rdata", cur), Hrdata, e.rdata);
                        check($sformatf("v%0d_pselx", cur), 32'(selseen), 32'(e.sel));
                        check($sformatf("v%0d_latency", cur), 32'(lat), 32'(e.lat));
                        if (e.sel != 4'h0) begin
                            check($sformatf("v%0d_paddr", cur), paddr_c, e.addr);
                            check($sformatf("v%0d_pwrite", cur), 32'(pwrite_c), 32'(e.write));
                            if (e.write) begin
                                check($sformatf("v%0d_pwdata", cur), pwdata_c, e.wdata);
                            end
                        end
                        blocked = (e.resp != 2'b00);
                    end
                end
            end
            if (!inflight && Hreadyout && !blocked && nxt <= hi) begin
                Htrans  = vt[nxt].trans;
                Haddr   = vt[nxt].addr;
                Hwrite  = vt[nxt].write;
                e.addr  = vt[nxt].addr;
                e.write = vt[nxt].write;
                e.wdata = vt[nxt].wdata;
                e.resp  = vt[nxt].resp;
                e.rdata = (!vt[nxt].write && vt[nxt].resp == 2'b00) ? vt[nxt].pdata : 32'h0;
                e.sel   = vt[nxt].sel;
                e.lat   = vt[nxt].lat;
                sb.push_back(e);
                cur      = nxt;
                nxt++;
                inflight = 1'b1;
                lat      = 0;
                acc      = 0;
                selseen  = '0;
            end else begin
                Htrans = 2'b00;
            end
            tick();
            budget++;
        end
        if (budget >= 200) begin
            check("stream_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pselx"}, 32'(Pselx), 32'h0);
        check({tag, "_penable"}, 32'(Penable), 32'h0);
        check({tag, "_pwrite"}, 32'(Pwrite), 32'h0);
        check({tag, "_paddr"}, Paddr, 32'h0);
        check({tag, "_pwdata"}, Pwdata, 32'h0);
        check({tag, "_hreadyout"}, 32'(Hreadyout), 32'h1);
        check({tag, "_hresp"}, 32'(Hresp), 32'h0);
        check({tag, "_hrdata"}, Hrdata, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        //          addr          wr    trans  wdata         pdata         wt err   resp   sel    lat
        vt[0]  = '{32'h8000_1004, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0BAD_0000, 0, 1'b0, 2'b00, 4'b0010, 3};
        vt[1]  = '{32'h8000_3000, 1'b0, 2'b10, 32'h0,         32'h1234_5678, 2, 1'b0, 2'b00, 4'b1000, 4};
        vt[2]  = '{32'h8000_4000, 1'b1, 2'b10, 32'h0000_0055, 32'h0,         0, 1'b0, 2'b01, 4'b0000, 2};
        vt[3]  = '{32'h8000_0010, 1'b0, 2'b10, 32'h0,         32'h7777_7777, 0, 1'b1, 2'b01, 4'b0001, 4};
        vt[4]  = '{32'h7FFF_FFFC, 1'b0, 2'b10, 32'h0,         32'h0,         0, 1'b0, 2'b01, 4'b0000, 2};
        vt[5]  = '{32'h8000_2FFC, 1'b1, 2'b10, 32'hA5A5_5A5A, 32'h0,         1, 1'b0, 2'b00, 4'b0100, 4};
        vt[6]  = '{32'h8000_0000, 1'b0, 2'b10, 32'h0,         32'h1111_0000, 0, 1'b0, 2'b00, 4'b0001, 2};
        vt[7]  = '{32'h8000_0004, 1'b0, 2'b11, 32'h0,         32'h2222_0001, 0, 1'b0, 2'b00, 4'b0001, 2};
        vt[8]  = '{32'h8000_0008, 1'b0, 2'b11, 32'h0,         32'h3333_0002, 0, 1'b0, 2'b00, 4'b0001, 2};
        vt[9]  = '{32'h8000_000C, 1'b0, 2'b11, 32'h0,         32'h4444_0003, 0, 1'b0, 2'b00, 4'b0001, 2};
        vt[10] = '{32'h8000_1FFC, 1'b0, 2'b10, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 2'b00, 4'b0010, 2};
        vt[11] = '{32'h8000_3008, 1'b1, 2'b10, 32'h0F0F_F0F0, 32'h0,         0, 1'b1, 2'b01, 4'b1000, 5};
        vt[12] = '{32'h8000_2010, 1'b0, 2'b10, 32'h0,         32'h600D_BEEF, 0, 1'b0, 2'b00, 4'b0100, 2};

        Hresetn  = 1'b1;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        Htrans   = 2'b00;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        Prdata   = '0;
        Pready   = 4'h0;
        Pslverr  = 4'h0;

        // Reset values, before and after clock edges
        #2 Hresetn = 1'b0;
        #1 check_reset_outputs("reset_async");
        tick();
        tick();
        check_reset_outputs("reset_held");
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();

        // IDLE and BUSY transfers to an in-window address: no APB activity
        Haddr = 32'h8000_1000;
        for (int k = 0; k < 4; k++) begin
            Htrans = (k < 2) ? 2'b01 : 2'b00;
            tick();
            check($sformatf("idlebusy%0d_pselx", k), 32'(Pselx), 32'h0);
            check($sformatf("idlebusy%0d_penable", k), 32'(Penable), 32'h0);
            check($sformatf("idlebusy%0d_ready", k), 32'(Hreadyout), 32'h1);
            check($sformatf("idlebusy%0d_resp", k), 32'(Hresp), 32'h0);
        end
        Htrans = 2'b00;

        run_vectors(0, 11);

        // Reset asserted during an ACCESS wait state
        Pready  = 4'h0;
        Pslverr = 4'h0;
        Htrans  = 2'b10;
        Haddr   = 32'h8000_2010;
        Hwrite  = 1'b0;
        tick();
        Htrans = 2'b00;
        waited = 0;
        while (!Penable && waited < 5) begin
            tick();
            waited++;
        end
        check("midreset_reached_access", 32'(Penable), 32'h1);
        check("midreset_pselx_before", 32'(Pselx), 32'h4);
        check("midreset_ready_before", 32'(Hreadyout), 32'h0);
        #1 Hresetn = 1'b0;
        #1 check_reset_outputs("midreset_async");
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();
        check("midreset_idle_after", 32'(Pselx), 32'h0);
        check("midreset_queue_empty", 32'(sb.size()), 32'h0);
        run_vectors(12, 12);

        tick();
        check("final_idle_ready", 32'(Hreadyout), 32'h1);
        check("final_queue_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
